serial_word_feeder: RTL and testbench

Upstream stage for the serial divisibility checker. Accepts parallel words over a valid/ready handshake and shifts them out one bit per clock, MSB first. The output is a registered bit stream with per-bit valid, start-of-word and end-of-word markers, so the running-modulus FSM downstream sees the number in the bit order it expects. Sits between the pin-level input capture (`ui_in`) and the checker's `in` bit.

---
 rtl/serial_word_feeder.sv | 117 +++++++++++
 tb/tb_serial_word_feeder.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_word_feeder.sv
// rtl/serial_word_feeder.sv - parallel word to MSB-first serial bit stream with sof/eof markers
// Optional one-word prefetch hold register: define SERIAL_FEEDER_PREFETCH_EN.
module serial_word_feeder #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] in_data,
   input  logic             in_valid,
   output logic             in_ready,
   output logic             ser_bit,
   output logic             ser_valid,
   output logic             ser_sof,
   output logic             ser_eof,
   output logic             busy
);

   localparam int CW = $clog2(WIDTH);
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   typedef enum logic {
      IDLE  = 1'b0,
      SHIFT = 1'b1
   } state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] sr_q, sr_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             accept;
   logic             last_bit;

`ifdef SERIAL_FEEDER_PREFETCH_EN
   logic [WIDTH-1:0] hold_q, hold_d;
   logic             hold_full_q, hold_full_d;

   assign in_ready = rst_n & ~hold_full_q;
   assign busy     = (state_q == SHIFT) | hold_full_q;
`else
   assign in_ready = rst_n & (state_q == IDLE);
   assign busy     = (state_q == SHIFT);
`endif

   assign accept    = in_valid & in_ready;
   assign last_bit  = (cnt_q == LAST);
   assign ser_valid = (state_q == SHIFT);
   assign ser_bit   = sr_q[WIDTH-1] & ser_valid;
   assign ser_sof   = ser_valid & (cnt_q == '0);
   assign ser_eof   = ser_valid & last_bit;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         sr_q        <= '0;
         cnt_q       <= '0;
`ifdef SERIAL_FEEDER_PREFETCH_EN
         hold_q      <= '0;
         hold_full_q <= 1'b0;
`endif
      end else begin
         state_q     <= state_d;
         sr_q        <= sr_d;
         cnt_q       <= cnt_d;
`ifdef SERIAL_FEEDER_PREFETCH_EN
         hold_q      <= hold_d;
         hold_full_q <= hold_full_d;
`endif
      end
   end

   always_comb begin
      state_d     = state_q;
      sr_d        = sr_q;
      cnt_d       = cnt_q;
`ifdef SERIAL_FEEDER_PREFETCH_EN
      hold_d      = hold_q;
      hold_full_d = hold_full_q;
`endif
      case (state_q)
         IDLE: begin
            if (accept) begin
               sr_d    = in_data;
               cnt_d   = '0;
               state_d = SHIFT;
            end
         end
         SHIFT: begin
            sr_d  = sr_q << 1;
            cnt_d = cnt_q + CW'(1);
            if (last_bit) begin
`ifdef SERIAL_FEEDER_PREFETCH_EN
               // held word first; accept is impossible while the hold is full
               if (hold_full_q) begin
                  sr_d        = hold_q;
                  cnt_d       = '0;
                  hold_full_d = 1'b0;
               end else if (accept) begin
                  sr_d  = in_data;
                  cnt_d = '0;
               end else begin
                  state_d = IDLE;
               end
`else
               state_d = IDLE;
`endif
            end
`ifdef SERIAL_FEEDER_PREFETCH_EN
            if (accept && !last_bit) begin
               hold_d      = in_data;
               hold_full_d = 1'b1;
            end
`endif
         end
         default: state_d = IDLE;
      endcase
   end

endmodule

// File: tb/tb_serial_word_feeder.sv
// tb/tb_serial_word_feeder.sv - directed self-checking bench for serial_word_feeder
// Expectations follow SERIAL_FEEDER_PREFETCH_EN when the bench is built with it.
module tb_serial_word_feeder;

   logic       clk;
   logic       rst_n;
   logic [7:0] in_data;
   logic       in_valid;
   logic       in_ready;
   logic       ser_bit;
   logic       ser_valid;
   logic       ser_sof;
   logic       ser_eof;
   logic       busy;

   int errors = 0;
   int checks = 0;

`ifdef SERIAL_FEEDER_PREFETCH_EN
   localparam logic RDY_SHIFT = 1'b1;
`else
   localparam logic RDY_SHIFT = 1'b0;
`endif

   serial_word_feeder #(.WIDTH(8)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_data   (in_data),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .ser_bit   (ser_bit),
      .ser_valid (ser_valid),
      .ser_sof   (ser_sof),
      .ser_eof   (ser_eof),
      .busy      (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic wait_ready(input string tag);
      int g = 0;
      while (!in_ready && g < 40) begin
         @(negedge clk);
         g++;
      end
      if (g >= 40) chk({tag, "_ready_timeout"}, 32'(in_ready), 32'd1);
   endtask

   task automatic wait_idle(input string tag);
      int g = 0;
      while (busy && g < 60) begin
         @(negedge clk);
         g++;
      end
      if (g >= 60) chk({tag, "_idle_timeout"}, 32'(busy), 32'd0);
      @(negedge clk);
   endtask

   // Sends w, checks all eight bit cycles, and optionally pulses in_valid at bit pulse_at.
   // exp_div >= 0 compares a mod-5 running remainder over the observed bits.
   task automatic send_word(input logic [7:0] w, input string tag, input int pulse_at,
                            input int exp_div);
      int rem = 0;
      @(negedge clk);
      in_data  = w;
      in_valid = 1'b1;
      wait_ready(tag);
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      for (int i = 0; i < 8; i++) begin
         if (i > 0) @(negedge clk);
         if (i == pulse_at) begin
            in_valid = 1'b1;
            in_data  = 8'hEE;
         end else begin
            in_valid = 1'b0;
         end
         chk($sformatf("%s_bit%0d", tag, i), 32'(ser_bit), 32'(w[7-i]));
         chk($sformatf("%s_vld%0d", tag, i), 32'(ser_valid), 32'd1);
         chk($sformatf("%s_sof%0d", tag, i), 32'(ser_sof), 32'(i == 0));
         chk($sformatf("%s_eof%0d", tag, i), 32'(ser_eof), 32'(i == 7));
         chk($sformatf("%s_rdy%0d", tag, i), 32'(in_ready), 32'(RDY_SHIFT));
         rem = (rem * 2 + int'(ser_bit)) % 5;
      end
      @(negedge clk);
      in_valid = 1'b0;
      chk({tag, "_after_vld"}, 32'(ser_valid), 32'd0);
      chk({tag, "_after_busy"}, 32'(busy), 32'd0);
      if (exp_div >= 0) chk({tag, "_div5"}, 32'(rem == 0), 32'(exp_div));
   endtask

   initial begin
      logic [16:0] vld;
      logic [16:0] bits;
      logic        drop;

      rst_n    = 1'b0;
      in_valid = 1'b0;
      in_data  = 8'h00;

      #12;
      chk("rst_ready", 32'(in_ready), 32'd0);
      chk("rst_vld",   32'(ser_valid), 32'd0);
      chk("rst_bit",   32'(ser_bit), 32'd0);
      chk("rst_sof",   32'(ser_sof), 32'd0);
      chk("rst_eof",   32'(ser_eof), 32'd0);
      chk("rst_busy",  32'(busy), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      chk("rel_ready", 32'(in_ready), 32'd1);

      send_word(8'hA5, "a5", -1, -1);
      send_word(8'd10, "d10", -1, 1);
      send_word(8'd11, "d11", -1, 0);

      // back-to-back FF then 00 with in_valid held high
      @(negedge clk);
      in_data  = 8'hFF;
      in_valid = 1'b1;
      wait_ready("b2b");
      @(posedge clk);
      vld  = '0;
      bits = '0;
      drop = 1'b0;
      for (int c = 0; c < 17; c++) begin
         @(negedge clk);
         if (c == 0) in_data = 8'h00;
         vld  = {vld[15:0], ser_valid};
         bits = {bits[15:0], ser_bit};
         if (drop) in_valid = 1'b0;
         if (in_valid && in_ready) drop = 1'b1;
      end
      in_valid = 1'b0;
`ifdef SERIAL_FEEDER_PREFETCH_EN
      chk("b2b_valid", 32'(vld), 32'(17'b11111111111111110));
`else
      chk("b2b_valid", 32'(vld), 32'(17'b11111111011111111));
`endif
      chk("b2b_bits", 32'(bits), 32'(17'b11111111000000000));
      wait_idle("b2b");

`ifdef SERIAL_FEEDER_PREFETCH_EN
      begin
         logic [7:0]  words [3];
         logic [23:0] obits;
         logic [9:0]  rdy;
         int          idx;
         logic        take;
         words[0] = 8'h11;
         words[1] = 8'h22;
         words[2] = 8'h33;
         @(negedge clk);
         in_data  = words[0];
         in_valid = 1'b1;
         wait_ready("hold");
         @(posedge clk);
         idx   = 0;
         take  = 1'b1;
         obits = '0;
         rdy   = '0;
         for (int c = 0; c < 24; c++) begin
            @(negedge clk);
            if (take) begin
               idx++;
               if (idx < 3) in_data = words[idx];
               else in_valid = 1'b0;
            end
            obits = {obits[22:0], ser_bit};
            if (c < 10) rdy = {rdy[8:0], in_ready};
            take = in_valid && in_ready;
         end
         in_valid = 1'b0;
         chk("hold_ready", 32'(rdy), 32'(10'b1000000010));
         chk("hold_order", 32'(obits), 32'h112233);
         wait_idle("hold");
      end
`endif

      // async reset after bit 3 of C3
      @(negedge clk);
      in_data  = 8'hC3;
      in_valid = 1'b1;
      wait_ready("c3");
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      chk("c3_bit0", 32'(ser_bit), 32'd1);
      @(negedge clk);
      chk("c3_bit1", 32'(ser_bit), 32'd1);
      @(negedge clk);
      chk("c3_bit2", 32'(ser_bit), 32'd0);
      @(negedge clk);
      #1 rst_n = 1'b0;
      #1;
      chk("ar_ready", 32'(in_ready), 32'd0);
      chk("ar_vld",   32'(ser_valid), 32'd0);
      chk("ar_bit",   32'(ser_bit), 32'd0);
      chk("ar_sof",   32'(ser_sof), 32'd0);
      chk("ar_eof",   32'(ser_eof), 32'd0);
      chk("ar_busy",  32'(busy), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      chk("ar_rel_vld",   32'(ser_valid), 32'd0);
      chk("ar_rel_ready", 32'(in_ready), 32'd1);
      send_word(8'h01, "post_rst", -1, -1);

`ifndef SERIAL_FEEDER_PREFETCH_EN
      send_word(8'h5A, "ign", 3, -1);
      begin
         logic seen = 1'b0;
         for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            seen = seen | ser_valid | ser_sof;
         end
         chk("ign_no_word", 32'(seen), 32'd0);
      end
      send_word(8'h3C, "after_ign", -1, -1);
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

endmodule
